// File: rtl/ysyx_23060240_lsu_axi_master.sv
// Load/store unit AXI4-Lite master.
// Takes one core request at a time. Each request becomes a single AXI read
// or write beat on a word-aligned address, or an immediate error response
// when the access is misaligned. Loads are lane-extracted and then sign- or
// zero-extended. Stores are replicated across the lanes and masked by wstrb.

module ysyx_23060240_lsu_axi_master #(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        ERR
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        wen_q;
    logic        aw_done;
    logic        w_done;
    logic        misaligned;

    // Selects the addressed byte, half or word from a bus beat and extends it
    // to 32 bits.
    function automatic logic [31:0] load_extract(input logic [1:0]  lo,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [31:0] beat);
        logic [7:0]  b;
        logic [15:0] h;
        b = beat[8*lo +: 8];
        h = beat[16*lo[1] +: 16];
        case (size)
            2'd0:    load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_extract = beat;
        endcase
    endfunction

    // Flags accesses that do not sit on their natural boundary.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Both channels use the word-aligned address of the latched request.
    // The write lanes are built from the latched data, so they stay stable
    // for the whole write.
    always_comb begin
        araddr = {addr_q[31:2], 2'b00};
        awaddr = {addr_q[31:2], 2'b00};
        wdata  = wdata_q;
        wstrb  = 4'b1111;
        case (size_q)
            2'd0: begin
                wdata = {4{wdata_q[7:0]}};
                wstrb = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                wdata = {2{wdata_q[15:0]}};
                wstrb = 4'b0011 << addr_q[1:0];
            end
            default: begin
                wdata = wdata_q;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Transaction FSM. All handshake and response outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            wen_q      <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wen_q      <= req_wen;
                        req_ready  <= 1'b0;
                        if (MISALIGN_CHK && misaligned) begin
                            state <= ERR;
                        end else if (req_wen) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= wen_q ? 32'h0
                                    : load_extract(addr_q[1:0], size_q, unsigned_q, rdata);
                        resp_err   <= (rresp != 2'b00);
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || (awvalid && awready)) &&
                        (w_done  || (wvalid  && wready))) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= (bresp != 2'b00);
                        resp_rdata <= 32'h0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_lsu_axi_master.sv
// Directed testbench for the LSU AXI master. Each task plays the core and the
// slave for one scenario and checks the DUT against hand-computed values.

module tb_ysyx_23060240_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  bresp;

    int checks = 0;
    int passes = 0;

    ysyx_23060240_lsu_axi_master #(.MISALIGN_CHK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Presents one request for a single edge. Called at #1 after a rising
    // edge with the DUT idle, so the request is accepted on that edge.
    task automatic send_req(input logic wen, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] size,
                            input logic uns);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wd; req_size = size; req_unsigned = uns;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); else passes++;
        checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0)
            $display("[TB] FAIL reset_axi_handshakes got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); else passes++;
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0)
            $display("[TB] FAIL reset_resp got %h/%b want 00000000/0", resp_rdata, resp_err); else passes++;
    endtask

    // Full load: request, AR phase with ar_wait stall cycles, R beat, response.
    task automatic do_read(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input int ar_wait, input logic [31:0] exp_araddr,
                           input logic [31:0] beat, input logic [1:0] rr,
                           input logic [31:0] exp_data, input logic exp_err);
        send_req(1'b0, addr, 32'h0, size, uns);
        checks++; if (req_ready !== 1'b0) $display("[TB] FAIL %s_req_ready got %b want 0", name, req_ready); else passes++;
        checks++; if (arvalid !== 1'b1 || araddr !== exp_araddr)
            $display("[TB] FAIL %s_ar got %b/%h want 1/%h", name, arvalid, araddr, exp_araddr); else passes++;
        for (int i = 0; i < ar_wait; i++) begin
            @(posedge clk); #1;
            checks++; if (arvalid !== 1'b1 || araddr !== exp_araddr || req_ready !== 1'b0)
                $display("[TB] FAIL %s_ar_hold got %b/%h/%b want 1/%h/0", name, arvalid, araddr, req_ready, exp_araddr); else passes++;
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1)
            $display("[TB] FAIL %s_rd_data_phase got arvalid %b rready %b want 0 1", name, arvalid, rready); else passes++;
        rvalid = 1'b1; rdata = beat; rresp = rr;
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_data || resp_err !== exp_err)
            $display("[TB] FAIL %s_resp got %b/%h/%b want 1/%h/%b", name, resp_valid, resp_rdata, resp_err, exp_data, exp_err); else passes++;
        checks++; if (rready !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL %s_after_resp got rready %b req_ready %b want 0 1", name, rready, req_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== exp_data || resp_err !== exp_err)
            $display("[TB] FAIL %s_resp_hold got %b/%h/%b want 0/%h/%b", name, resp_valid, resp_rdata, resp_err, exp_data, exp_err); else passes++;
    endtask

    // Full store: the slave raises awready from cycle aw_wait and wready from
    // cycle w_wait, counts handshakes, then answers with bresp.
    task automatic do_write(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wd, input int aw_wait, input int w_wait,
                            input logic [31:0] exp_awaddr, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb, input logic [1:0] br, input logic exp_err);
        int aw_cnt = 0;
        int w_cnt  = 0;
        logic got_bready = 1'b0;
        send_req(1'b1, addr, wd, size, 1'b0);
        for (int c = 0; c < 30 && !got_bready; c++) begin
            awready = (c >= aw_wait);
            wready  = (c >= w_wait);
            #1;
            if (bready) begin
                got_bready = 1'b1;
            end else begin
                if (awvalid && awready) begin
                    aw_cnt++;
                    checks++; if (awaddr !== exp_awaddr)
                        $display("[TB] FAIL %s_awaddr got %h want %h", name, awaddr, exp_awaddr); else passes++;
                end
                if (wvalid && wready) begin
                    w_cnt++;
                    checks++; if (wdata !== exp_wdata || wstrb !== exp_wstrb)
                        $display("[TB] FAIL %s_w got %h/%b want %h/%b", name, wdata, wstrb, exp_wdata, exp_wstrb); else passes++;
                end
                @(posedge clk); #1;
            end
        end
        awready = 1'b0; wready = 1'b0;
        checks++; if (got_bready !== 1'b1) $display("[TB] FAIL %s_bready_timeout got 0 want 1", name); else passes++;
        checks++; if (aw_cnt != 1 || w_cnt != 1)
            $display("[TB] FAIL %s_handshakes got aw %0d w %0d want 1 1", name, aw_cnt, w_cnt); else passes++;
        bvalid = 1'b1; bresp = br;
        @(posedge clk); #1;
        bvalid = 1'b0; bresp = 2'b00;
        checks++; if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== 32'h0)
            $display("[TB] FAIL %s_resp got %b/%b/%h want 1/%b/00000000", name, resp_valid, resp_err, resp_rdata, exp_err); else passes++;
        checks++; if (bready !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL %s_after_resp got bready %b req_ready %b want 0 1", name, bready, req_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL %s_resp_pulse got %b want 0", name, resp_valid); else passes++;
    endtask

    task automatic test_load_byte();
        do_read("lb", 32'h8000_0003, 2'd0, 1'b0, 0, 32'h8000_0000,
                32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 1'b0);
        do_read("lbu", 32'h8000_0001, 2'd0, 1'b1, 0, 32'h8000_0000,
                32'h80FF_1234, 2'b00, 32'h0000_0012, 1'b0);
    endtask

    task automatic test_store_half();
        do_write("sh", 32'h8000_0002, 2'd1, 32'h0000_BEEF, 1, 3,
                 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 2'b00, 1'b0);
    endtask

    task automatic test_store_variants();
        do_write("sb_same_cycle", 32'h8000_0001, 2'd0, 32'h1234_56A5, 0, 0,
                 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 2'b10, 1'b1);
        do_write("sw_w_first", 32'h8000_0008, 2'd2, 32'hCAFE_F00D, 2, 0,
                 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 2'b00, 1'b0);
    endtask

    task automatic test_misaligned();
        logic saw_ar = 1'b0;
        send_req(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
        saw_ar = arvalid;
        checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL misalign_early_resp got %b want 0", resp_valid); else passes++;
        @(posedge clk); #1;
        saw_ar = saw_ar | arvalid;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0)
            $display("[TB] FAIL misalign_resp got %b/%b/%h want 1/1/00000000", resp_valid, resp_err, resp_rdata); else passes++;
        @(posedge clk); #1;
        saw_ar = saw_ar | arvalid;
        checks++; if (saw_ar !== 1'b0) $display("[TB] FAIL misalign_arvalid got 1 want 0"); else passes++;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("[TB] FAIL misalign_after got resp_valid %b req_ready %b want 0 1", resp_valid, req_ready); else passes++;
    endtask

    task automatic test_ar_stall();
        do_read("lw_stall", 32'h8000_0004, 2'd2, 1'b0, 5, 32'h8000_0004,
                32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_read("lw_slverr", 32'h8000_0000, 2'd2, 1'b0, 0, 32'h8000_0000,
                32'h1122_3344, 2'b10, 32'h1122_3344, 1'b1);
        do_read("lhu", 32'h8000_0002, 2'd1, 1'b1, 0, 32'h8000_0000,
                32'h9ABC_0000, 2'b00, 32'h0000_9ABC, 1'b0);
        do_read("lh", 32'h8000_0002, 2'd1, 1'b0, 1, 32'h8000_0000,
                32'h9ABC_0000, 2'b00, 32'hFFFF_9ABC, 1'b0);
    endtask

    task automatic test_reset_in_wr_resp();
        logic got_bready = 1'b0;
        logic saw_resp = 1'b0;
        send_req(1'b1, 32'h8000_0010, 32'h5555_AAAA, 2'd2, 1'b0);
        awready = 1'b1; wready = 1'b1;
        for (int c = 0; c < 10 && !got_bready; c++) begin
            if (bready) got_bready = 1'b1;
            else begin @(posedge clk); #1; end
        end
        awready = 1'b0; wready = 1'b0;
        checks++; if (got_bready !== 1'b1) $display("[TB] FAIL rst_wr_resp_reach got 0 want 1"); else passes++;
        #2 rst = 1'b0;
        #1;
        checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0)
            $display("[TB] FAIL rst_wr_resp_axi got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); else passes++;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("[TB] FAIL rst_wr_resp_core got req_ready %b resp_valid %b want 1 0", req_ready, resp_valid); else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            saw_resp = saw_resp | resp_valid | bready;
            @(posedge clk); #1;
        end
        checks++; if (saw_resp !== 1'b0) $display("[TB] FAIL rst_wr_resp_no_resp got 1 want 0"); else passes++;
        do_read("lbu_after_rst", 32'h8000_0012, 2'd0, 1'b1, 0, 32'h8000_0010,
                32'h00C3_0000, 2'b00, 32'h0000_00C3, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        test_load_byte();
        test_store_half();
        test_store_variants();
        test_misaligned();
        test_ar_stall();
        test_back_to_back();
        test_reset_in_wr_resp();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
